sw_debounce: RTL and testbench
==============================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter N_CH, default 8: number of independent switch/button channels (1..16).
REQ-002 SHALL have parameter DB_CYCLES, default 2_000_000: debounce window in clk cycles, which is 20 ms at 100 MHz; legal range 2 or more.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth, 2 or more.
REQ-004 SHALL use one clock; reset is asynchronous and active-low. Ports: clk and rst_n.
REQ-005 clk  input  1  system clock, all state rising-edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 sw_in  input  N_CH  raw asynchronous board switches/buttons; bit 0 drives the LED direction select downstream.
REQ-008 sw_level  output  N_CH  debounced stable level per channel.
REQ-009 sw_rise  output  N_CH  one-cycle pulse when sw_level goes 0 to 1.
REQ-010 sw_fall  output  N_CH  one-cycle pulse when sw_level goes 1 to 0.
REQ-011 busy  output  1  high while any channel is in a check state.

Function
REQ-012 Each sw_in bit SHALL pass through SYNC_STAGES flops before any other logic samples it.
REQ-013 Each channel SHALL run its own FSM with these states:
- S_LOW: level 0.
- S_CHK_H: candidate high.
- S_HIGH: level 1.
- S_CHK_L: candidate low.
REQ-014 Transitions from the stable states:
- S_LOW with synced=1: go to S_CHK_H, cnt set to 1.
- S_HIGH with synced=0: go to S_CHK_L, cnt set to 1.
- Otherwise hold, cnt=0.
REQ-015 Transitions from the check states:
- Synced equal to the current level: return to the stable state, cnt=0.
- Differing sample with cnt==DB_CYCLES-1: commit to the opposite stable state, cnt=0.
- Otherwise cnt increments.
REQ-016 sw_level SHALL change on the clock edge that samples the DB_CYCLES-th consecutive differing synced value. Total latency from a raw edge is SYNC_STAGES+DB_CYCLES clock edges.
REQ-017 sw_rise/sw_fall SHALL be registered and high exactly during the first cycle sw_level shows the new value.
REQ-018 A glitch shorter than DB_CYCLES synced cycles SHALL leave sw_level, sw_rise and sw_fall unchanged and clear cnt.
REQ-019 The counter SHALL be $clog2(DB_CYCLES) bits wide per channel, never wrap, and never exceed DB_CYCLES-1.
REQ-020 Channels SHALL be fully independent; simultaneous commits on several channels SHALL pulse all of them in the same cycle.
REQ-021 busy SHALL be the registered OR of all channels being in S_CHK_H or S_CHK_L.

Reset
REQ-022 While rst_n=0 the block SHALL hold:
- Synchronizer flops, sw_level, sw_rise, sw_fall, busy and all cnt at 0.
- All FSMs in S_LOW.
REQ-023 Reset asserted mid-check SHALL abort the check with no pulse.
REQ-024 An input held high through reset deassertion SHALL produce sw_level=1 with one sw_rise pulse after the normal latency.

Configuration
REQ-025 Macro SW_DEBOUNCE_EDGE_EN defined: sw_rise/sw_fall SHALL be generated per REQ-017.
REQ-026 Macro SW_DEBOUNCE_EDGE_EN undefined: sw_rise/sw_fall SHALL be tied to 0, the edge registers SHALL be absent, and sw_level behaviour SHALL be identical.

Structure
REQ-027 Package sw_debounce_pkg SHALL hold the state enum type db_state_t (S_LOW, S_CHK_H, S_HIGH, S_CHK_L) and the default DB_CYCLES constant.
REQ-028 Per-channel synchronizer, FSM and counter SHALL live in sub-module sw_debounce_ch, generated N_CH times.
REQ-029 The top SHALL contain only the generate loop and the busy OR.

Verification (bench uses DB_CYCLES=4, SYNC_STAGES=2, N_CH=2)
REQ-030 Clean rise: sw_in[0] goes 0 to 1 before edge 0 and is held. Required: sw_level[0]=1 and sw_rise[0]=1 after edge 5, then sw_rise[0]=0 after edge 6.
REQ-031 Glitch: sw_in[0] high for 3 cycles, then low. Required: sw_level[0] stays 0, no pulse, busy high 3 cycles then 0.
REQ-032 Fall: from sw_level[0]=1, sw_in[0] goes to 0 and is held. Required: sw_level[0]=0 with a one-cycle sw_fall[0] 6 edges later.
REQ-033 Simultaneous: sw_in=2'b11 applied at once. Required: sw_rise=2'b11 in the same cycle.
REQ-034 Reset mid-check: rst_n pulsed low at cnt=2, input held high. Required: outputs 0 during reset, and sw_level=1 six edges after rst_n rises.
REQ-035 Macro SW_DEBOUNCE_EDGE_EN undefined: rerun REQ-030. Required: identical sw_level, with sw_rise and sw_fall constant 0.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
// The optional SW_DEBOUNCE_EDGE_EN macro enables the sw_rise/sw_fall edge registers.
package sw_debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW   = 2'd0,
        S_CHK_H = 2'd1,
        S_HIGH  = 2'd2,
        S_CHK_L = 2'd3
    } db_state_t;

    localparam int DB_CYCLES_DEFAULT   = 2_000_000;
    localparam int SYNC_STAGES_DEFAULT = 2;

    function automatic logic is_check(db_state_t s);
        return (s == S_CHK_H) || (s == S_CHK_L);
    endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// One debounce channel: input synchronizer, four-state FSM and run counter.
// With SW_DEBOUNCE_EDGE_EN defined it also registers one-cycle rise/fall pulses.
module sw_debounce_ch
    import sw_debounce_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic chk
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   synced;
    db_state_t              state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   level_reg, level_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = sync_reg[SYNC_STAGES-1];

    // cnt counts consecutive samples that disagree with the current level;
    // commit happens on the DB_CYCLES-th one, so cnt tops out at DB_CYCLES-1.
    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        case (state_reg)
            S_LOW: begin
                if (synced) begin
                    state_next = S_CHK_H;
                    cnt_next   = CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!synced) begin
                    state_next = S_CHK_L;
                    cnt_next   = CNT_ONE;
                end
            end
            S_CHK_H: begin
                if (!synced) begin
                    state_next = S_LOW;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = S_HIGH;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            S_CHK_L: begin
                if (synced) begin
                    state_next = S_HIGH;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = S_LOW;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: state_next = S_LOW;
        endcase
    end

    assign level_next = (state_next == S_HIGH) || (state_next == S_CHK_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_LOW;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
        end
    end

    assign level = level_reg;
    assign chk   = is_check(state_reg);

`ifdef SW_DEBOUNCE_EDGE_EN
    logic rise_reg, fall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            rise_reg <= level_next & ~level_reg;
            fall_reg <= ~level_next & level_reg;
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer: N_CH independent channels plus a registered busy flag.
// Define SW_DEBOUNCE_EDGE_EN to enable the sw_rise/sw_fall pulse outputs.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] sw_level,
    output logic [N_CH-1:0] sw_rise,
    output logic [N_CH-1:0] sw_fall,
    output logic            busy
);

    logic [N_CH-1:0] chk;
    logic            busy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            sw_debounce_ch #(
                .DB_CYCLES  (DB_CYCLES),
                .SYNC_STAGES(SYNC_STAGES)
            ) u_ch (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (sw_in[gi]),
                .level(sw_level[gi]),
                .rise (sw_rise[gi]),
                .fall (sw_fall[gi]),
                .chk  (chk[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= 1'b0;
        end else begin
            busy_reg <= |chk;
        end
    end

    assign busy = busy_reg;

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce (N_CH=2, DB_CYCLES=4, SYNC_STAGES=2).
// Works with or without SW_DEBOUNCE_EDGE_EN defined.
module tb_sw_debounce;

    localparam int N_CH = 2;
    localparam int DB   = 4;
    localparam int SYNC = 2;
`ifdef SW_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] sw_in = '0;
    logic [N_CH-1:0] sw_level, sw_rise, sw_fall;
    logic            busy;

    int n_pass  = 0;
    int n_total = 0;

    sw_debounce #(.N_CH(N_CH), .DB_CYCLES(DB), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .sw_in(sw_in),
        .sw_level(sw_level), .sw_rise(sw_rise), .sw_fall(sw_fall), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: raw input delayed SYNC edges; level flips after DB consecutive
    // delayed samples disagreeing with it; busy shows "some run in progress" one cycle late.
    logic [N_CH-1:0] m_lvl, m_rise, m_fall;
    logic            m_busy;
    int              m_run [N_CH];
    logic            m_dly [N_CH][SYNC];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lvl = '0; m_rise = '0; m_fall = '0; m_busy = 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                m_run[c] = 0;
                for (int k = 0; k < SYNC; k++) m_dly[c][k] = 1'b0;
            end
        end else begin
            m_busy = 1'b0;
            for (int c = 0; c < N_CH; c++) if (m_run[c] > 0) m_busy = 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                logic s;
                s = m_dly[c][SYNC-1];
                for (int k = SYNC-1; k > 0; k--) m_dly[c][k] = m_dly[c][k-1];
                m_dly[c][0] = sw_in[c];
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (s != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB) begin
                        m_lvl[c] = s;
                        if (s) m_rise[c] = EDGE_EN; else m_fall[c] = EDGE_EN;
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw_in = N_CH'($urandom);
        repeat (3) begin
            tick();
            n_total++;
            if ({sw_level, sw_rise, sw_fall, busy} !== '0) begin
                $display("FAIL reset_hold: got lvl=%b rise=%b fall=%b busy=%b, want all 0",
                         sw_level, sw_rise, sw_fall, busy);
            end else n_pass++;
        end
        sw_in = '0;
        rst_n = 1'b1;
        repeat (4) tick();
        $display("test_reset done");
    endtask

    task automatic test_clean_rise();
        sw_in = 2'b01;
        for (int e = 0; e < 8; e++) begin
            tick();
            n_total++;
            if ({sw_level, sw_rise, sw_fall, busy} !== {m_lvl, m_rise, m_fall, m_busy}) begin
                $display("FAIL rise_model e=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e,
                         sw_level, sw_rise, sw_fall, busy, m_lvl, m_rise, m_fall, m_busy);
            end else n_pass++;
            if (e == 4 || e == 5 || e == 6) begin
                n_total++;
                if (sw_level[0] !== (e >= 5) || sw_rise[0] !== (e == 5 && EDGE_EN)) begin
                    $display("FAIL rise_edge%0d: got lvl=%b rise=%b, want lvl=%b rise=%b", e,
                             sw_level[0], sw_rise[0], (e >= 5), (e == 5 && EDGE_EN));
                end else n_pass++;
            end
        end
        $display("test_clean_rise done");
    endtask

    task automatic test_fall();
        sw_in = 2'b00;
        for (int e = 0; e < 9; e++) begin
            tick();
            n_total++;
            if ({sw_level, sw_rise, sw_fall, busy} !== {m_lvl, m_rise, m_fall, m_busy}) begin
                $display("FAIL fall_model e=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e,
                         sw_level, sw_rise, sw_fall, busy, m_lvl, m_rise, m_fall, m_busy);
            end else n_pass++;
            if (e == 4 || e == 5 || e == 6) begin
                n_total++;
                if (sw_level[0] !== (e < 5) || sw_fall[0] !== (e == 5 && EDGE_EN)) begin
                    $display("FAIL fall_edge%0d: got lvl=%b fall=%b, want lvl=%b fall=%b", e,
                             sw_level[0], sw_fall[0], (e < 5), (e == 5 && EDGE_EN));
                end else n_pass++;
            end
        end
        $display("test_fall done");
    endtask

    task automatic test_glitch();
        int busy_cycles = 0;
        int bad = 0;
        sw_in = 2'b01;
        for (int e = 0; e < 12; e++) begin
            if (e == 3) sw_in = 2'b00;
            tick();
            if (busy === 1'b1) busy_cycles++;
            if (sw_level !== 2'b00 || sw_rise !== 2'b00 || sw_fall !== 2'b00) bad++;
            n_total++;
            if ({sw_level, sw_rise, sw_fall, busy} !== {m_lvl, m_rise, m_fall, m_busy}) begin
                $display("FAIL glitch_model e=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e,
                         sw_level, sw_rise, sw_fall, busy, m_lvl, m_rise, m_fall, m_busy);
            end else n_pass++;
        end
        n_total++;
        if (busy_cycles != 3 || bad != 0) begin
            $display("FAIL glitch_summary: busy_cycles=%0d output_changes=%0d, want 3 and 0",
                     busy_cycles, bad);
        end else n_pass++;
        $display("test_glitch done");
    endtask

    task automatic test_simultaneous();
        sw_in = 2'b11;
        for (int e = 0; e < 8; e++) begin
            tick();
            n_total++;
            if ({sw_level, sw_rise, sw_fall, busy} !== {m_lvl, m_rise, m_fall, m_busy}) begin
                $display("FAIL simul_model e=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e,
                         sw_level, sw_rise, sw_fall, busy, m_lvl, m_rise, m_fall, m_busy);
            end else n_pass++;
            if (e == 5) begin
                n_total++;
                if (sw_level !== 2'b11 || sw_rise !== (EDGE_EN ? 2'b11 : 2'b00)) begin
                    $display("FAIL simul_pulse: got lvl=%b rise=%b, want lvl=11 rise=%b",
                             sw_level, sw_rise, (EDGE_EN ? 2'b11 : 2'b00));
                end else n_pass++;
            end
        end
        sw_in = 2'b00;
        repeat (8) tick();
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_mid_check();
        sw_in = 2'b01;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({sw_level, sw_rise, sw_fall, busy} !== '0) begin
            $display("FAIL midrst_async: got lvl=%b rise=%b fall=%b busy=%b, want all 0",
                     sw_level, sw_rise, sw_fall, busy);
        end else n_pass++;
        repeat (2) begin
            tick();
            n_total++;
            if ({sw_level, sw_rise, sw_fall, busy} !== '0) begin
                $display("FAIL midrst_hold: got lvl=%b rise=%b fall=%b busy=%b, want all 0",
                         sw_level, sw_rise, sw_fall, busy);
            end else n_pass++;
        end
        rst_n = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            n_total++;
            if (sw_level[0] !== (e >= 5) || sw_rise[0] !== (e == 5 && EDGE_EN)) begin
                $display("FAIL midrst_recover e=%0d: got lvl=%b rise=%b, want lvl=%b rise=%b", e,
                         sw_level[0], sw_rise[0], (e >= 5), (e == 5 && EDGE_EN));
            end else n_pass++;
        end
        sw_in = 2'b00;
        repeat (8) tick();
        $display("test_reset_mid_check done");
    endtask

    task automatic test_random();
        int hold = 0;
        for (int e = 0; e < 400; e++) begin
            if (hold == 0) begin
                sw_in = N_CH'($urandom);
                hold  = $urandom_range(1, 2 * DB + 2);
            end
            hold--;
            tick();
            n_total++;
            if ({sw_level, sw_rise, sw_fall, busy} !== {m_lvl, m_rise, m_fall, m_busy}) begin
                $display("FAIL random_model e=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e,
                         sw_level, sw_rise, sw_fall, busy, m_lvl, m_rise, m_fall, m_busy);
            end else n_pass++;
        end
        $display("test_random done");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_rise();
        test_fall();
        test_glitch();
        test_simultaneous();
        test_reset_mid_check();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
